hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 36 +++
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_fwd_sel.sv | 26 ++
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the five-stage (A fetch .. E writeback) hazard controller.
// Holds the FSM state enum, the forward-select encodings and the register-match helpers.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        MWAIT = 1'b1
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_RF   = 2'b00,
        FWD_E    = 2'b01,
        FWD_D    = 2'b10,
        FWD_HOLD = 2'b11
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // x0 is hardwired to zero, so it never takes part in a hazard or a forward
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

    function automatic logic hits_src(input logic we, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2);
        return we && (reg_match(rd, rs1) || reg_match(rd, rs2));
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. The pipeline side is the master
// (drives register ids and memory handshake), the hazard unit is the slave.
interface hazard_ctrl_if #(
    parameter int DATA_WIDTH = 32
);
    logic [4:0]            Rs1B, Rs2B;
    logic [4:0]            Rs1C, Rs2C, RdC;
    logic                  RegWriteC;
    logic [1:0]            ResultSrcC;
    logic                  PCSrcC;
    logic [4:0]            RdD;
    logic                  RegWriteD;
    logic                  MemReqD, MemReadyD;
    logic [4:0]            RdE;
    logic                  RegWriteE;
    logic [DATA_WIDTH-1:0] WrDataE;

    logic                  StallA, StallB, StallC, StallD;
    logic                  FlushB, FlushC;
    logic [1:0]            ForwardAC, ForwardBC;
    logic [DATA_WIDTH-1:0] FwdDataC;
    logic                  MemErr;
    logic [15:0]           StallCnt;

    modport master (
        output Rs1B, Rs2B, Rs1C, Rs2C, RdC, RegWriteC, ResultSrcC, PCSrcC,
               RdD, RegWriteD, MemReqD, MemReadyD, RdE, RegWriteE, WrDataE,
        input  StallA, StallB, StallC, StallD, FlushB, FlushC,
               ForwardAC, ForwardBC, FwdDataC, MemErr, StallCnt
    );

    modport slave (
        input  Rs1B, Rs2B, Rs1C, Rs2C, RdC, RegWriteC, ResultSrcC, PCSrcC,
               RdD, RegWriteD, MemReqD, MemReadyD, RdE, RegWriteE, WrDataE,
        output StallA, StallB, StallC, StallD, FlushB, FlushC,
               ForwardAC, ForwardBC, FwdDataC, MemErr, StallCnt
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Operand forward selector for one C-stage source register.
// The D stage is the youngest producer, so it wins over E, which wins over the held writeback.
module hazard_fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_d,
    input  logic       reg_write_d,
    input  logic [4:0] rd_e,
    input  logic       reg_write_e,
    input  logic       wb_hold,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (reg_write_d && reg_match(rd_d, rs)) begin
            sel = FWD_D;
        end else if (reg_write_e && reg_match(rd_e, rs)) begin
            sel = FWD_E;
        end else if (wb_hold && (rs != 5'd0)) begin
            sel = FWD_HOLD;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: memory-wait freeze, branch redirect, load-use/RAW stalls and forwarding.
// Define HAZARD_FORWARDING_EN to enable operand forwarding; otherwise RAW hazards stall in B.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    hazard_ctrl_if.slave bus
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    hz_state_e             state;
    logic [7:0]            wait_cnt;
    logic                  mem_err;
    logic [15:0]           stall_cnt;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  wb_hold1, wb_hold2;
    logic                  freeze, load_use, data_stall;
    logic                  stall_a, stall_b, stall_c, stall_d;
    logic                  flush_b, flush_c;
    logic [1:0]            sel_a, sel_b;

    // Outputs are gated by rst_n so a reset asserted mid-wait drops every stall at once
    assign freeze   = rst_n && bus.MemReqD && !bus.MemReadyD && !mem_err;
    assign load_use = bus.RegWriteC && (bus.ResultSrcC == RESULT_SRC_LOAD)
                      && hits_src(1'b1, bus.RdC, bus.Rs1B, bus.Rs2B);

`ifdef HAZARD_FORWARDING_EN
    assign data_stall = load_use;
`else
    assign data_stall = load_use
                        || hits_src(bus.RegWriteC, bus.RdC, bus.Rs1B, bus.Rs2B)
                        || hits_src(bus.RegWriteD, bus.RdD, bus.Rs1B, bus.Rs2B)
                        || hits_src(bus.RegWriteE, bus.RdE, bus.Rs1B, bus.Rs2B);
`endif

    always_comb begin
        stall_a = 1'b0;
        stall_b = 1'b0;
        stall_c = 1'b0;
        stall_d = 1'b0;
        flush_b = 1'b0;
        flush_c = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                stall_a = 1'b1;
                stall_b = 1'b1;
                stall_c = 1'b1;
                stall_d = 1'b1;
            end else if (bus.PCSrcC) begin
                flush_b = 1'b1;
                flush_c = 1'b1;
            end else if (data_stall) begin
                stall_a = 1'b1;
                stall_b = 1'b1;
                flush_c = 1'b1;
            end
        end
    end

    // Memory-wait FSM; the timeout lands on the cycle WaitCnt reaches MEM_TIMEOUT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (freeze) begin
                        state    <= MWAIT;
                        wait_cnt <= 8'd0;
                    end
                end
                MWAIT: begin
                    if (bus.MemReadyD) begin
                        state <= RUN;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if ((wait_cnt + 8'd1) == TIMEOUT) begin
                            mem_err <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if (stall_b && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

    hazard_fwd_sel u_fwd_a (
        .rs          (bus.Rs1C),
        .rd_d        (bus.RdD),
        .reg_write_d (bus.RegWriteD),
        .rd_e        (bus.RdE),
        .reg_write_e (bus.RegWriteE),
        .wb_hold     (wb_hold1),
        .sel         (sel_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs          (bus.Rs2C),
        .rd_d        (bus.RdD),
        .reg_write_d (bus.RegWriteD),
        .rd_e        (bus.RdE),
        .reg_write_e (bus.RegWriteE),
        .wb_hold     (wb_hold2),
        .sel         (sel_b)
    );

`ifdef HAZARD_FORWARDING_EN
    // B read the regfile in the same cycle E wrote it, so keep that value for one cycle in C
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_hold1 <= 1'b0;
            wb_hold2 <= 1'b0;
            fwd_data <= '0;
        end else if (!stall_b) begin
            wb_hold1 <= bus.RegWriteE && reg_match(bus.RdE, bus.Rs1B);
            wb_hold2 <= bus.RegWriteE && reg_match(bus.RdE, bus.Rs2B);
            if (hits_src(bus.RegWriteE, bus.RdE, bus.Rs1B, bus.Rs2B)) begin
                fwd_data <= bus.WrDataE;
            end
        end else begin
            wb_hold1 <= 1'b0;
            wb_hold2 <= 1'b0;
        end
    end

    assign bus.ForwardAC = rst_n ? sel_a : FWD_RF;
    assign bus.ForwardBC = rst_n ? sel_b : FWD_RF;
`else
    logic unused_ok;

    assign wb_hold1      = 1'b0;
    assign wb_hold2      = 1'b0;
    assign fwd_data      = '0;
    assign bus.ForwardAC = FWD_RF;
    assign bus.ForwardBC = FWD_RF;
    assign unused_ok     = ^{bus.WrDataE, sel_a, sel_b};
`endif

    assign bus.StallA   = stall_a;
    assign bus.StallB   = stall_b;
    assign bus.StallC   = stall_c;
    assign bus.StallD   = stall_d;
    assign bus.FlushB   = flush_b;
    assign bus.FlushC   = flush_c;
    assign bus.FwdDataC = fwd_data;
    assign bus.MemErr   = mem_err;
    assign bus.StallCnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4); expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.DATA_WIDTH(32)) bus ();

    hazard_ctrl #(
        .DATA_WIDTH  (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ctl = {StallA, StallB, StallC, StallD, FlushB, FlushC}
    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic [1:0]  fwA;
        logic [1:0]  fwB;
        logic [31:0] fd;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        expQ[$];
    int          total  = 0;
    int          bad    = 0;
    int          expCnt = 0;
    logic [31:0] expFd  = 32'd0;
    logic        expErr = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic idle();
        bus.Rs1B = 5'd0;  bus.Rs2B = 5'd0;
        bus.Rs1C = 5'd0;  bus.Rs2C = 5'd0;  bus.RdC = 5'd0;
        bus.RegWriteC = 1'b0;  bus.ResultSrcC = 2'b00;  bus.PCSrcC = 1'b0;
        bus.RdD = 5'd0;  bus.RegWriteD = 1'b0;
        bus.MemReqD = 1'b0;  bus.MemReadyD = 1'b0;
        bus.RdE = 5'd0;  bus.RegWriteE = 1'b0;  bus.WrDataE = 32'd0;
    endtask

    task automatic setLoadUse();
        bus.RegWriteC = 1'b1;  bus.ResultSrcC = 2'b01;  bus.RdC = 5'd5;
        bus.Rs1B = 5'd5;  bus.Rs2B = 5'd1;
    endtask

    task automatic popAndCheck();
        exp_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("%s.StallA", e.tag), 32'(bus.StallA), 32'(e.ctl[5]));
        checkOutput($sformatf("%s.StallB", e.tag), 32'(bus.StallB), 32'(e.ctl[4]));
        checkOutput($sformatf("%s.StallC", e.tag), 32'(bus.StallC), 32'(e.ctl[3]));
        checkOutput($sformatf("%s.StallD", e.tag), 32'(bus.StallD), 32'(e.ctl[2]));
        checkOutput($sformatf("%s.FlushB", e.tag), 32'(bus.FlushB), 32'(e.ctl[1]));
        checkOutput($sformatf("%s.FlushC", e.tag), 32'(bus.FlushC), 32'(e.ctl[0]));
        checkOutput($sformatf("%s.ForwardAC", e.tag), 32'(bus.ForwardAC), 32'(e.fwA));
        checkOutput($sformatf("%s.ForwardBC", e.tag), 32'(bus.ForwardBC), 32'(e.fwB));
        checkOutput($sformatf("%s.FwdDataC", e.tag), bus.FwdDataC, e.fd);
        checkOutput($sformatf("%s.MemErr", e.tag), 32'(bus.MemErr), 32'(e.err));
        checkOutput($sformatf("%s.StallCnt", e.tag), 32'(bus.StallCnt), 32'(e.cnt));
    endtask

    // Inputs are already driven; queue the expectation, sample mid-cycle, then advance
    task automatic applyStimulus(input string tag, input logic [5:0] ctl,
                                 input logic [1:0] fwA, input logic [1:0] fwB);
        exp_t e;
        e.tag = tag;
        e.ctl = ctl;
        e.fwA = fwA;
        e.fwB = fwB;
        e.fd  = expFd;
        e.err = expErr;
        e.cnt = 16'(expCnt);
        expQ.push_back(e);
        @(negedge clk);
        popAndCheck();
        if (ctl[4]) expCnt++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset_idle", 6'b000000, 2'b00, 2'b00);

        rst_n = 1'b1;
        applyStimulus("run_idle", 6'b000000, 2'b00, 2'b00);

        // lw x5 in C, add x6,x5,x1 in B; then the add reaches C with the load in D
        setLoadUse();
        applyStimulus("load_use", 6'b110001, 2'b00, 2'b00);
        idle();
        bus.Rs1C = 5'd5;  bus.Rs2C = 5'd1;  bus.RdC = 5'd6;  bus.RegWriteC = 1'b1;
        bus.RdD = 5'd5;  bus.RegWriteD = 1'b1;
        bus.Rs1B = 5'd2;  bus.Rs2B = 5'd3;
        applyStimulus("load_fwd", 6'b000000, FWD ? 2'b10 : 2'b00, 2'b00);

        idle();
        setLoadUse();
        bus.PCSrcC = 1'b1;
        applyStimulus("redirect", 6'b000011, 2'b00, 2'b00);

        idle();
        bus.RegWriteC = 1'b1;  bus.ResultSrcC = 2'b01;
        bus.RegWriteD = 1'b1;  bus.RegWriteE = 1'b1;  bus.WrDataE = 32'h1111_2222;
        applyStimulus("x0_nomatch", 6'b000000, 2'b00, 2'b00);

        // E writes x7 while B reads x7
        idle();
        bus.RegWriteE = 1'b1;  bus.RdE = 5'd7;  bus.WrDataE = 32'hDEAD_BEEF;  bus.Rs1B = 5'd7;
        applyStimulus("wb_raw", FWD ? 6'b000000 : 6'b110001, 2'b00, 2'b00);
        idle();
        bus.Rs1C = 5'd7;
        if (FWD) expFd = 32'hDEAD_BEEF;
        applyStimulus("wb_hold", 6'b000000, FWD ? 2'b11 : 2'b00, 2'b00);

        idle();
        bus.RegWriteD = 1'b1;  bus.RdD = 5'd9;  bus.Rs2B = 5'd9;
        applyStimulus("d_raw", FWD ? 6'b000000 : 6'b110001, 2'b00, 2'b00);

        idle();
        bus.RegWriteE = 1'b1;  bus.RdE = 5'd12;  bus.WrDataE = 32'h1234_5678;
        bus.Rs1B = 5'd3;  bus.Rs2B = 5'd12;
        applyStimulus("wb_raw2", FWD ? 6'b000000 : 6'b110001, 2'b00, 2'b00);
        idle();
        bus.Rs2C = 5'd12;
        if (FWD) expFd = 32'h1234_5678;
        applyStimulus("wb_hold2", 6'b000000, 2'b00, FWD ? 2'b11 : 2'b00);

        idle();
        bus.RegWriteD = 1'b1;  bus.RdD = 5'd4;  bus.RegWriteE = 1'b1;  bus.RdE = 5'd4;
        bus.Rs1C = 5'd4;  bus.Rs2C = 5'd4;
        applyStimulus("fwd_prio", 6'b000000, FWD ? 2'b10 : 2'b00, FWD ? 2'b10 : 2'b00);
        idle();
        bus.RegWriteE = 1'b1;  bus.RdE = 5'd4;  bus.Rs2C = 5'd4;
        applyStimulus("fwd_e", 6'b000000, 2'b00, FWD ? 2'b01 : 2'b00);

        // Three-cycle memory wait, with a redirect hidden under the freeze
        idle();
        bus.MemReqD = 1'b1;
        applyStimulus("freeze1", 6'b111100, 2'b00, 2'b00);
        bus.PCSrcC = 1'b1;
        applyStimulus("freeze_redirect", 6'b111100, 2'b00, 2'b00);
        bus.PCSrcC = 1'b0;
        setLoadUse();
        applyStimulus("freeze3", 6'b111100, 2'b00, 2'b00);
        idle();
        bus.MemReqD = 1'b1;  bus.MemReadyD = 1'b1;
        applyStimulus("mem_ready", 6'b000000, 2'b00, 2'b00);
        idle();
        applyStimulus("post_mem", 6'b000000, 2'b00, 2'b00);

        // Memory never answers: entry cycle plus four MWAIT cycles, then MemErr
        bus.MemReqD = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus($sformatf("tmo%0d", i), 6'b111100, 2'b00, 2'b00);
        end
        expErr = 1'b1;
        applyStimulus("tmo_err", 6'b000000, 2'b00, 2'b00);
        setLoadUse();
        applyStimulus("err_loaduse", 6'b110001, 2'b00, 2'b00);

        rst_n = 1'b0;
        idle();
        expErr = 1'b0;
        expCnt = 0;
        expFd  = 32'd0;
        applyStimulus("reset_err", 6'b000000, 2'b00, 2'b00);

        // Reset asserted while sitting in MWAIT with the request still pending
        rst_n = 1'b1;
        bus.MemReqD = 1'b1;
        applyStimulus("mw_a", 6'b111100, 2'b00, 2'b00);
        applyStimulus("mw_b", 6'b111100, 2'b00, 2'b00);
        rst_n  = 1'b0;
        expCnt = 0;
        applyStimulus("reset_mwait", 6'b000000, 2'b00, 2'b00);
        rst_n = 1'b1;
        idle();
        applyStimulus("after_reset", 6'b000000, 2'b00, 2'b00);
        bus.MemReqD = 1'b1;
        applyStimulus("refreeze", 6'b111100, 2'b00, 2'b00);
        bus.MemReadyD = 1'b1;
        applyStimulus("refreeze_ready", 6'b000000, 2'b00, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
